// File: rtl/handle_port_arbiter.sv
// Round-robin arbiter sharing one handle_handler between NUM_REQ requester ports,
// with an atomic ALLOC (query free handle id, then map it) command.
`timescale 1ns/1ps
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef HNDL_WIDTH
`define HNDL_WIDTH 4
`endif

module handle_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int HNDL_WIDTH = `HNDL_WIDTH
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*2-1:0]          i_req_op,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_address,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  input  logic [NUM_REQ-1:0]            i_rsp_ready,
  output logic [ADDR_WIDTH-1:0]         o_rsp_address,
  output logic [ADDR_WIDTH-1:0]         o_rsp_data,
  output logic [2:0]                    o_h_op,
  output logic [ADDR_WIDTH-1:0]         o_h_address,
  output logic [ADDR_WIDTH-1:0]         o_h_data,
  input  logic [ADDR_WIDTH-1:0]         i_h_address,
  input  logic [ADDR_WIDTH-1:0]         i_h_data,
  output logic [2:0]                    o_dbg_state
);

  localparam int GW = $clog2(NUM_REQ);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_QUERY = 3'd2;
  localparam logic [2:0] S_MAP   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] OP_ALLOC = 2'd3;
  localparam logic [2:0] H_NOP    = 3'd0;
  localparam logic [2:0] H_READ   = 3'd1;
  localparam logic [2:0] H_WRITE  = 3'd2;

  // Handle-command address: top HNDL_WIDTH+1 bits set, id in the low bits.
  function automatic logic [ADDR_WIDTH-1:0] cmd_addr(input logic [HNDL_WIDTH-1:0] id);
    logic [ADDR_WIDTH-1:0] a;
    a = '0;
    a[ADDR_WIDTH-1 -: HNDL_WIDTH+1] = '1;
    a[HNDL_WIDTH-1:0] = id;
    return a;
  endfunction

  logic [2:0]            state;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         cur;
  logic [1:0]            lat_op;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [ADDR_WIDTH-1:0] lat_data;
  logic [HNDL_WIDTH-1:0] free_id;

  logic [1:0]            req_op   [NUM_REQ];
  logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] req_data [NUM_REQ];

  logic                  any_valid;
  logic [GW-1:0]         grant;
  logic [NUM_REQ-1:0]    grant_onehot;
  logic [NUM_REQ-1:0]    cur_onehot;
  logic [HNDL_WIDTH-1:0] query_id;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_op[k]   = i_req_op[2*k +: 2];
      req_addr[k] = i_req_address[ADDR_WIDTH*k +: ADDR_WIDTH];
      req_data[k] = i_req_data[ADDR_WIDTH*k +: ADDR_WIDTH];
    end
  end

  // Round-robin: first valid port strictly after last_grant, wrapping.
  always_comb begin
    int            idx;
    logic [GW-1:0] cand;
    idx       = 0;
    cand      = '0;
    any_valid = 1'b0;
    grant     = last_grant;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx  = (int'(last_grant) + i) % NUM_REQ;
      cand = GW'(idx);
      if (!any_valid && i_req_valid[cand]) begin
        any_valid = 1'b1;
        grant     = cand;
      end
    end
  end

  assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;
  assign cur_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << cur;
  assign query_id     = i_h_data[HNDL_WIDTH-1:0];
  assign o_dbg_state  = state;

  // Handshakes: o_req_ready is a one-cycle registered pulse in the cycle after the
  // grant decision (request is taken on that decision edge, held inputs are then
  // free to change); a response transfers on any edge where o_rsp_valid[g] and
  // i_rsp_ready[g] are both high, and o_rsp_valid/o_rsp_* stay stable until then.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= S_IDLE;
      last_grant    <= GW'(NUM_REQ-1);
      cur           <= '0;
      lat_op        <= '0;
      lat_addr      <= '0;
      lat_data      <= '0;
      free_id       <= '0;
      o_req_ready   <= '0;
      o_rsp_valid   <= '0;
      o_rsp_address <= '0;
      o_rsp_data    <= '0;
    end else begin
      o_req_ready <= '0;
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            o_req_ready <= grant_onehot;
            cur         <= grant;
            last_grant  <= grant;
            lat_op      <= req_op[grant];
            lat_addr    <= req_addr[grant];
            lat_data    <= req_data[grant];
            state       <= (req_op[grant] == OP_ALLOC) ? S_QUERY : S_ISSUE;
          end
        end
        S_ISSUE: begin
          o_rsp_address <= i_h_address;
          o_rsp_data    <= i_h_data;
          o_rsp_valid   <= cur_onehot;
          state         <= S_RESP;
        end
        S_QUERY: begin
          free_id <= query_id;
          // No free cell, or a zero base that would invalidate the handle: fail now.
          if ((query_id == '1) || (lat_data == '0)) begin
            o_rsp_address <= '0;
            o_rsp_data    <= '1;
            o_rsp_valid   <= cur_onehot;
            state         <= S_RESP;
          end else begin
            state <= S_MAP;
          end
        end
        S_MAP: begin
          o_rsp_address <= '0;
          o_rsp_data    <= cmd_addr(free_id);
          o_rsp_valid   <= cur_onehot;
          state         <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready[cur]) begin
            o_rsp_valid <= '0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_h_op      = H_NOP;
    o_h_address = '0;
    o_h_data    = '0;
    case (state)
      S_ISSUE: begin
        o_h_op      = {1'b0, lat_op};
        o_h_address = lat_addr;
        o_h_data    = lat_data;
      end
      S_QUERY: begin
        o_h_op      = H_READ;
        o_h_address = cmd_addr('1);
      end
      S_MAP: begin
        o_h_op      = H_WRITE;
        o_h_address = cmd_addr(free_id);
        o_h_data    = lat_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_handle_port_arbiter.sv
// Self-checking bench for handle_port_arbiter: handler model, per-request scoreboard,
// directed round-robin / ALLOC / back-pressure / reset scenarios plus random traffic.
`timescale 1ns/1ps

module tb_handle_port_arbiter;

  localparam int AW = 16;
  localparam logic [15:0] GET_AVAIL = 16'hF80F;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [1:0]  i_req_valid = '0;
  logic [1:0]  o_req_ready;
  logic [3:0]  i_req_op = '0;
  logic [31:0] i_req_address = '0;
  logic [31:0] i_req_data = '0;
  logic [1:0]  o_rsp_valid;
  logic [1:0]  i_rsp_ready = 2'b11;
  logic [15:0] o_rsp_address;
  logic [15:0] o_rsp_data;
  logic [2:0]  o_h_op;
  logic [15:0] o_h_address;
  logic [15:0] o_h_data;
  logic [15:0] i_h_address;
  logic [15:0] i_h_data;
  logic [2:0]  o_dbg_state;

  handle_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(16), .HNDL_WIDTH(4)) dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_op(i_req_op),
    .i_req_address(i_req_address), .i_req_data(i_req_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_address(o_rsp_address), .o_rsp_data(o_rsp_data),
    .o_h_op(o_h_op), .o_h_address(o_h_address), .o_h_data(o_h_data),
    .i_h_address(i_h_address), .i_h_data(i_h_data), .o_dbg_state(o_dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // handler model: translation offset, free-id word returned by get-available
  logic [15:0] xlate = 16'h0000;
  logic [15:0] free_word = 16'h0003;

  always_comb begin
    i_h_address = 16'h0;
    i_h_data    = 16'h0;
    case (o_h_op)
      3'd1: begin
        i_h_address = o_h_address + xlate;
        i_h_data    = (o_h_address == GET_AVAIL) ? free_word : (o_h_address ^ 16'hA5A5);
      end
      3'd2: begin
        i_h_address = o_h_address + xlate;
        i_h_data    = o_h_data;
      end
      default: ;
    endcase
  end

  // scoreboard state: {latency_from_ready[1:0], port, rsp_address, rsp_data}
  logic [34:0] exp_q[$];
  int          cyc_q[$];
  logic [34:0] h_log[$];
  int          grant_log[$];
  int          rdy_cyc_log[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cycle = 0;
  bit          hold_valid = 1'b0;
  bit          rand_rdy = 1'b0;
  bit          prev_vld = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
  endtask

  function automatic logic [34:0] model(input int port, input logic [1:0] op,
                                        input logic [15:0] a, input logic [15:0] d);
    logic [15:0] ra, rd;
    logic [1:0]  lat;
    ra = 16'h0; rd = 16'h0; lat = 2'd1;
    case (op)
      2'd1: begin ra = a + xlate; rd = a ^ 16'hA5A5; end
      2'd2: begin ra = a + xlate; rd = d; end
      2'd3: begin
        if (free_word[3:0] == 4'hF || d == 16'h0) rd = 16'hFFFF;
        else begin rd = 16'hF800 | {12'h0, free_word[3:0]}; lat = 2'd2; end
      end
      default: ;
    endcase
    return {lat, 1'(port), ra, rd};
  endfunction

  task automatic observe();
    logic [34:0] e;
    int          c;
    for (int k = 0; k < 2; k++) begin
      if (o_req_ready[k]) begin
        grant_log.push_back(k);
        rdy_cyc_log.push_back(cycle);
        exp_q.push_back(model(k, i_req_op[2*k +: 2], i_req_address[16*k +: 16], i_req_data[16*k +: 16]));
        cyc_q.push_back(cycle);
        if (!hold_valid) i_req_valid[k] = 1'b0;
      end
    end
    if (o_h_op != 3'd0) h_log.push_back({o_h_op, o_h_address, o_h_data});
    if ((|o_rsp_valid) && !prev_vld) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'(o_rsp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("rsp_port", 64'(o_rsp_valid), 64'(2'b01 << e[32]));
        check("rsp_address", 64'(o_rsp_address), 64'(e[31:16]));
        check("rsp_data", 64'(o_rsp_data), 64'(e[15:0]));
        check("rsp_latency", 64'(cycle - c), 64'(e[34:33]));
      end
    end
    prev_vld = |o_rsp_valid;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    observe();
    if (rand_rdy) i_rsp_ready = 2'($urandom_range(0, 3));
  endtask

  task automatic set_req(input int p, input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
    i_req_op[2*p +: 2]       = op;
    i_req_address[16*p +: 16] = a;
    i_req_data[16*p +: 16]    = d;
    i_req_valid[p]            = 1'b1;
  endtask

  task automatic do_req(input int p, input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
    int n;
    n = 0;
    set_req(p, op, a, d);
    while (i_req_valid[p] && n < 40) begin tick(); n++; end
    check("req_accepted", 64'(i_req_valid[p]), 64'd0);
    i_req_valid[p] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_rdy    = 1'b0;
    i_rsp_ready = 2'b11;
    while ((exp_q.size() != 0 || (|o_rsp_valid) || (|i_req_valid) || o_dbg_state != 3'd0) && n < 100) begin
      tick(); n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    logic [15:0] sa, sd;
    logic [1:0]  op;

    // reset
    repeat (3) tick();
    i_reset = 1'b0;
    tick();
    check("rst_req_ready", 64'(o_req_ready), 64'd0);
    check("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    check("rst_h_op", 64'(o_h_op), 64'd0);
    check("rst_h_bus", 64'({o_h_address, o_h_data}), 64'd0);
    check("rst_rsp_bus", 64'({o_rsp_address, o_rsp_data}), 64'd0);
    check("rst_state", 64'(o_dbg_state), 64'd0);

    // round-robin with both ports holding READ valid
    grant_log.delete(); rdy_cyc_log.delete();
    hold_valid = 1'b1;
    set_req(0, 2'd1, 16'h1000, 16'h0);
    set_req(1, 2'd1, 16'h2000, 16'h0);
    n = 0;
    while (grant_log.size() < 4 && n < 40) begin tick(); n++; end
    i_req_valid = 2'b00;
    hold_valid  = 1'b0;
    check("rr_grant_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("rr_grant_order", 64'(grant_log[i]), 64'(i % 2));
    for (int i = 1; i < 4 && i < rdy_cyc_log.size(); i++)
      check("rr_ready_spacing", 64'(rdy_cyc_log[i] - rdy_cyc_log[i-1]), 64'd3);
    drain();

    // ALLOC success: free id 3, base 0x0400
    free_word = 16'h0003;
    h_log.delete();
    do_req(1, 2'd3, 16'h0, 16'h0400);
    drain();
    check("alloc_h_count", 64'(h_log.size()), 64'd2);
    if (h_log.size() >= 2) begin
      check("alloc_query", 64'(h_log[0]), 64'({3'd1, 16'hF80F, 16'h0000}));
      check("alloc_map", 64'(h_log[1]), 64'({3'd2, 16'hF803, 16'h0400}));
    end

    // ALLOC fail: no free cell
    free_word = 16'hFFFF;
    h_log.delete();
    do_req(0, 2'd3, 16'h0, 16'h0400);
    drain();
    check("allocfail_h_count", 64'(h_log.size()), 64'd1);
    if (h_log.size() >= 1) check("allocfail_query_op", 64'(h_log[0][34:32]), 64'd1);

    // ALLOC with zero base: map skipped
    free_word = 16'h0005;
    h_log.delete();
    do_req(1, 2'd3, 16'h0, 16'h0000);
    drain();
    check("alloczero_h_count", 64'(h_log.size()), 64'd1);

    // translate: handler adds the mapped base
    xlate = 16'h0400;
    h_log.delete();
    do_req(0, 2'd1, 16'h1234, 16'h0);
    drain();
    if (h_log.size() >= 1) check("xlate_issue", 64'(h_log[0][34:16]), 64'({3'd1, 16'h1234}));
    check("xlate_h_count", 64'(h_log.size()), 64'd1);
    do_req(1, 2'd2, 16'h0042, 16'hBEEF);
    do_req(0, 2'd0, 16'h0077, 16'h1111);
    drain();

    // back-pressure on port 0 while port 1 waits
    i_rsp_ready = 2'b00;
    do_req(0, 2'd1, 16'h0100, 16'h0);
    set_req(1, 2'd1, 16'h0200, 16'h0);
    n = 0;
    while (!o_rsp_valid[0] && n < 10) begin tick(); n++; end
    check("bp_rsp_seen", 64'(o_rsp_valid), 64'd1);
    sa = o_rsp_address; sd = o_rsp_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 64'(o_rsp_valid), 64'd1);
      check("bp_hold_rsp", 64'({o_rsp_address, o_rsp_data}), 64'({sa, sd}));
      check("bp_h_nop", 64'(o_h_op), 64'd0);
      check("bp_no_grant", 64'(o_req_ready), 64'd0);
    end
    i_rsp_ready = 2'b11;
    n = 0;
    while (!o_req_ready[1] && n < 10) begin tick(); n++; end
    check("bp_grant_delay", 64'(n), 64'd2);
    drain();

    // random traffic with random response back-pressure
    free_word = 16'h0006;
    rand_rdy  = 1'b1;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      sa = 16'($urandom_range(0, 16'hEFFF));
      sd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
      do_req($urandom_range(0, 1), op, sa, sd);
    end
    drain();

    // reset during QUERY of an ALLOC
    free_word = 16'h0003;
    h_log.delete();
    set_req(1, 2'd3, 16'h0, 16'h0400);
    n = 0;
    while (!o_req_ready[1] && n < 10) begin tick(); n++; end
    check("mid_state_query", 64'(o_dbg_state), 64'd2);
    i_reset = 1'b1;
    tick();
    exp_q.delete(); cyc_q.delete();
    check("mid_rst_state", 64'(o_dbg_state), 64'd0);
    check("mid_rst_outs", 64'({o_req_ready, o_rsp_valid, o_h_op}), 64'd0);
    check("mid_rst_buses", 64'({o_h_address, o_h_data, o_rsp_address, o_rsp_data}), 64'd0);
    i_reset = 1'b0;
    tick();
    n = 0;
    foreach (h_log[i]) if (h_log[i][34:32] == 3'd2) n++;
    check("mid_rst_no_map", 64'(n), 64'd0);
    grant_log.delete();
    set_req(0, 2'd1, 16'h0300, 16'h0);
    set_req(1, 2'd1, 16'h0400, 16'h0);
    n = 0;
    while (grant_log.size() == 0 && n < 10) begin tick(); n++; end
    check("post_rst_first_grant", 64'((grant_log.size() > 0) ? grant_log[0] : 9), 64'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
